// File: rtl/j6502_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// j6502_bus_ctrl_if
// Bus bundle between the 6502 core, the bus controller and the peripherals.
//   phi2, cpu_addr, cpu_rw_n, cpu_data_out : CPU cycle request
//   cpu_data_in, cpu_rdy                   : read data / ready back to the CPU
//   dev_cs, dev_addr, dev_wdata, dev_we    : decoded device-side access
//   dev_rdata, dev_wait                    : per-device read data / extension
//   bus_err                                : unmapped or timed-out access pulse
// Per-device vectors (dev_cs, dev_rdata, dev_wait) carry device 0 in the
// most-significant slice, matching the DEV_* parameter packing.
// Modports: slave = bus controller view, master = CPU/peripheral side.
// ---------------------------------------------------------------------------
interface j6502_bus_ctrl_if #(
   parameter int N_DEV = 4,
   parameter int AW    = 16,
   parameter int DW    = 8
);
   logic                  phi2;
   logic [AW-1:0]         cpu_addr;
   logic                  cpu_rw_n;
   logic [DW-1:0]         cpu_data_out;
   logic [DW-1:0]         cpu_data_in;
   logic                  cpu_rdy;
   logic [N_DEV-1:0]      dev_cs;
   logic [AW-1:0]         dev_addr;
   logic [DW-1:0]         dev_wdata;
   logic                  dev_we;
   logic [N_DEV*DW-1:0]   dev_rdata;
   logic [N_DEV-1:0]      dev_wait;
   logic                  bus_err;

   modport slave (
      input  phi2, cpu_addr, cpu_rw_n, cpu_data_out, dev_rdata, dev_wait,
      output cpu_data_in, cpu_rdy, dev_cs, dev_addr, dev_wdata, dev_we, bus_err
   );

   modport master (
      output phi2, cpu_addr, cpu_rw_n, cpu_data_out, dev_rdata, dev_wait,
      input  cpu_data_in, cpu_rdy, dev_cs, dev_addr, dev_wdata, dev_we, bus_err
   );
endinterface

// File: rtl/j6502_bus_ctrl.sv
// ---------------------------------------------------------------------------
// j6502_bus_ctrl
// Decodes each 6502 bus cycle against N_DEV address windows, drives a one-hot
// chip select, stretches the cycle through cpu_rdy for fixed and device
// requested wait states, returns registered read data and issues a one-cycle
// write strobe.
// Ports:
//   fst_clk : system clock, rising edge
//   res     : synchronous active-high reset
//   bus     : j6502_bus_ctrl_if.slave (CPU request, device access, status)
// Optional feature: define J6502_BUSCTRL_TIMEOUT_EN to force-complete a cycle
// that stays in WAIT for TIMEOUT clocks (reads return all ones, writes are
// dropped, bus_err pulses).
// ---------------------------------------------------------------------------
module j6502_bus_ctrl #(
   parameter int                  N_DEV    = 4,
   parameter int                  AW       = 16,
   parameter int                  DW       = 8,
   parameter int                  WS_W     = 4,
   parameter logic [N_DEV*AW-1:0] DEV_BASE = {16'hC000, 16'h6000, 16'h5000, 16'h0000},
   parameter logic [N_DEV*AW-1:0] DEV_MASK = {16'hC000, 16'hFFF0, 16'hFFFC, 16'h8000},
   parameter logic [N_DEV*WS_W-1:0] DEV_WS = {4'd1, 4'd2, 4'd0, 4'd0},
   parameter int                  TIMEOUT  = 255
) (
   input  logic              fst_clk,
   input  logic              res,
   j6502_bus_ctrl_if.slave   bus
);

   localparam int SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              phi2_q, phi2_d;
   logic [WS_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              rw_n_q, rw_n_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [N_DEV-1:0]  cs_q, cs_d;
   logic              we_q, we_d;
   logic              err_q, err_d;

   logic [AW-1:0]     base_a  [N_DEV];
   logic [AW-1:0]     mask_a  [N_DEV];
   logic [WS_W-1:0]   ws_a    [N_DEV];
   logic [DW-1:0]     rdata_a [N_DEV];
   logic              wait_a  [N_DEV];
   logic [N_DEV-1:0]  hit_v;       // indexed by device number
   logic [N_DEV-1:0]  onehot_s;    // device 0 in the MS bit, like dev_cs
   logic              hit_s;
   logic [SEL_W-1:0]  sel_s;
   logic              phi2_rise_s, phi2_fall_s;
   logic              complete_s;
   logic              expire_s;

   // Unpack the device-0-in-MS-slice vectors into per-device arrays.
   for (genvar g = 0; g < N_DEV; g++) begin : g_dev
      assign base_a[g]              = DEV_BASE[(N_DEV-1-g)*AW +: AW];
      assign mask_a[g]              = DEV_MASK[(N_DEV-1-g)*AW +: AW];
      assign ws_a[g]                = DEV_WS[(N_DEV-1-g)*WS_W +: WS_W];
      assign rdata_a[g]             = bus.dev_rdata[(N_DEV-1-g)*DW +: DW];
      assign wait_a[g]              = bus.dev_wait[N_DEV-1-g];
      assign hit_v[g]               = ((bus.cpu_addr & mask_a[g]) == base_a[g]);
      assign onehot_s[N_DEV-1-g]    = hit_s && (sel_s == SEL_W'(g));
   end

   // Priority decode: scanning from the top index down leaves the lowest hit.
   always_comb begin
      hit_s = 1'b0;
      sel_s = {SEL_W{1'b0}};
      for (int i = N_DEV - 1; i >= 0; i--) begin
         sel_s = hit_v[i] ? SEL_W'(i) : sel_s;
         hit_s = hit_s | hit_v[i];
      end
   end

   assign phi2_d      = bus.phi2;
   assign phi2_rise_s = bus.phi2 & ~phi2_q;
   assign phi2_fall_s = ~bus.phi2 & phi2_q;
   assign complete_s  = (cnt_q == {WS_W{1'b0}}) && !wait_a[sel_q];

`ifdef J6502_BUSCTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_q, to_d;

   // Timeout counter: cleared while idle, counts every WAIT clock.
   always_comb begin
      if (state_q == ST_IDLE) begin
         to_d = {TO_W{1'b0}};
      end else if (state_q == ST_WAIT) begin
         to_d = to_q + TO_W'(1);
      end else begin
         to_d = to_q;
      end
   end

   // Timeout counter register.
   always_ff @(posedge fst_clk) begin
      if (res) begin
         to_q <= {TO_W{1'b0}};
      end else begin
         to_q <= to_d;
      end
   end

   // Fires in the last allowed WAIT clock, so cpu_rdy is low TIMEOUT clocks.
   assign expire_s = (state_q == ST_WAIT) && !complete_s &&
                     (to_q == TO_W'(TIMEOUT - 1));
`else
   assign expire_s = 1'b0;
`endif

   // Bus-cycle FSM: next state, latches, strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      rw_n_d  = rw_n_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cs_d    = cs_q;
      we_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (phi2_rise_s) begin
               addr_d  = bus.cpu_addr;
               rw_n_d  = bus.cpu_rw_n;
               wdata_d = bus.cpu_data_out;
               sel_d   = sel_s;
               cnt_d   = ws_a[sel_s];
               if (hit_s) begin
                  state_d = ST_WAIT;
                  cs_d    = onehot_s;
               end else begin
                  state_d = ST_HOLD;
                  rdata_d = {DW{1'b1}};
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // phi2 edges are ignored here; only completion or expiry leaves.
            if (complete_s || expire_s) begin
               if (expire_s) begin
                  rdata_d = rw_n_q ? {DW{1'b1}} : rdata_q;
                  err_d   = 1'b1;
               end else if (rw_n_q) begin
                  rdata_d = rdata_a[sel_q];
               end else begin
                  we_d    = 1'b1;
               end
               // A phi2 fall coinciding with completion ends the cycle at once.
               if (phi2_fall_s) begin
                  state_d = ST_IDLE;
                  cs_d    = {N_DEV{1'b0}};
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               cnt_d = (cnt_q != {WS_W{1'b0}}) ? cnt_q - WS_W'(1) : cnt_q;
            end
         end
         ST_HOLD: begin
            if (phi2_fall_s) begin
               state_d = ST_IDLE;
               cs_d    = {N_DEV{1'b0}};
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_d    = {N_DEV{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset aborts any access in flight.
   always_ff @(posedge fst_clk) begin
      if (res) begin
         state_q <= ST_IDLE;
         phi2_q  <= 1'b0;
         cnt_q   <= {WS_W{1'b0}};
         sel_q   <= {SEL_W{1'b0}};
         rw_n_q  <= 1'b1;
         addr_q  <= {AW{1'b0}};
         wdata_q <= {DW{1'b0}};
         rdata_q <= {DW{1'b1}};
         cs_q    <= {N_DEV{1'b0}};
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phi2_q  <= phi2_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         rw_n_q  <= rw_n_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign bus.cpu_data_in = rdata_q;
   assign bus.cpu_rdy     = !((state_q == ST_WAIT) && !complete_s);
   assign bus.dev_cs      = cs_q;
   assign bus.dev_addr    = addr_q;
   assign bus.dev_wdata   = wdata_q;
   assign bus.dev_we      = we_q;
   assign bus.bus_err     = err_q;

endmodule
